gwct_apb_master: RTL and testbench
==================================

# gwct_apb_master

Command-to-APB bridge for the GWCT debug path. Sits directly downstream of the packet framing layer: it accepts one decoded read/write command pulse, runs a single APB3 transfer on the debug bus, and returns read data plus an error flag as a one-cycle completion pulse. Stalled slaves are bounded by a watchdog, and misaligned addresses are rejected before any bus activity.

## Interface
- TIMEOUT_CYCLES, 1024: maximum ACCESS-phase cycles without `pready` before the transfer is abandoned. Legal range 2..65535.
- ADDR_ALIGN_CHECK, 1: when 1, any `cmd_addr[1:0] != 0` is rejected with an error.

- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- cmd_addr  in  32  byte address. Sampled only when `cmd_valid` is high.
- cmd_wdata  in  32  write data. Sampled only when `cmd_valid` is high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_valid  in  1  one-cycle command strobe.
- cmd_ready  out  1  one-cycle completion strobe.
- cmd_rdata  out  32  read data. Valid with `cmd_ready` and held until the next completion.
- cmd_error  out  1  error flag. Valid with `cmd_ready` and held until the next completion.
- paddr  out  32  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  32  APB write data.
- prdata  in  32  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

## Operation
- Reset values: all outputs are 0. State = IDLE. Timeout counter = 0.
- FSM states are IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - On `cmd_valid`, latch addr, wdata and write into `paddr`, `pwdata` and `pwrite`.
  - If `ADDR_ALIGN_CHECK` is set and `addr[1:0] != 0`: set `err_q = 1`, `rdata_q = 0`, and go to RESP. No APB activity occurs.
  - Otherwise go to SETUP.
- **SETUP**
  - `psel = 1`, `penable = 0`.
  - Always advance to ACCESS and clear the counter.
- **ACCESS**
  - `psel = 1`, `penable = 1`.
  - If `pready`:
    - `rdata_q` = `prdata` for a read, 0 for a write.
    - `err_q` = `pslverr`; if `pslverr` is set, force `rdata_q` to 0.
    - Go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: `err_q = 1`, `rdata_q = 0`, go to RESP.
  - Else increment the counter.
- **RESP**
  - `psel = 0`, `penable = 0`.
  - Pulse `cmd_ready = 1` for exactly one cycle, driving `cmd_rdata = rdata_q` and `cmd_error = err_q`.
  - Return to IDLE.
- `paddr`, `pwrite` and `pwdata` stay stable from SETUP through ACCESS, and keep their last values afterwards.
- `cmd_valid` outside IDLE is ignored (dropped, not queued). The upstream layer issues no new command until `cmd_ready`.
- Counter width is `$clog2(TIMEOUT_CYCLES)` bits, and it never wraps.
- `rst` asserted mid-transfer drops `psel`/`penable` asynchronously. No `cmd_ready` is issued for the aborted command.

## Timing
- `psel`, `penable` and `cmd_ready` are registered outputs.
- Zero-wait-state transfer:
  - `cmd_valid` high in cycle 0.
  - SETUP (`psel`) in cycle 1.
  - ACCESS (`penable`) in cycle 2, with `pready` sampled high.
  - `cmd_ready` high in cycle 3.
- Each wait state adds one cycle.
- Misaligned reject: `cmd_valid` in cycle 0, `cmd_ready` in cycle 1.
- Timeout: ACCESS lasts exactly TIMEOUT_CYCLES cycles, then `cmd_ready` follows in the next cycle.
- Back-to-back: a `cmd_valid` in the cycle after `cmd_ready` is accepted.

## Structure
- Shared header `gwct_defs.vh` holds:
  - CMD_READ = 8'h01, CMD_WRITE = 8'h02, magic 8'h47;
  - FSM encodings APB_IDLE=0, APB_SETUP=1, APB_ACCESS=2, APB_RESP=3.
- One natural sub-module: `gwct_watchdog` (clear/enable/expire counter parameterised by TIMEOUT_CYCLES). Everything else is flat.

## Test plan
- Read 0x0000_0010 with slave returning 0xDEADBEEF at zero wait → `psel` in cycle 1, `penable` in cycle 2, `cmd_ready` in cycle 3 with `cmd_rdata` = 0xDEADBEEF and `cmd_error` = 0.
- Write 0x12345678 to 0x0000_0004 with 3 wait states → `pwdata`/`paddr`/`pwrite` stable for 4 ACCESS cycles, `cmd_ready` in cycle 6, `cmd_rdata` = 0, `cmd_error` = 0.
- Read with `pslverr` = 1 and `prdata` = 0xFFFFFFFF → `cmd_error` = 1, `cmd_rdata` = 0.
- `pready` held low, TIMEOUT_CYCLES = 8 → ACCESS for exactly 8 cycles, then `psel` drops, `cmd_ready` is pulsed with `cmd_error` = 1 and `cmd_rdata` = 0. The next read completes normally.
- Read 0x0000_0003 → no `psel` ever asserted, `cmd_ready` in cycle 1 with `cmd_error` = 1.
- Assert `rst` during ACCESS → `psel`/`penable` go low immediately and no `cmd_ready` is issued. A new read after reset completes correctly. A `cmd_valid` pulsed during SETUP is ignored.

Source files
------------

// File: rtl/gwct_apb_master_pkg.sv
// Shared definitions for the GWCT debug-path APB bridge.
// Command opcodes, framing magic and FSM encoding.
package gwct_apb_master_pkg;

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_MAGIC = 8'h47;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2,
        APB_RESP   = 2'd3
    } apb_state_e;

    function automatic logic is_misaligned(input logic [31:0] addr,
                                           input int          check);
        return (check != 0) && (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/gwct_watchdog.sv
// ACCESS-phase watchdog: saturating counter that flags the last
// permitted wait cycle.
module gwct_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    // Holds at LAST instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/gwct_apb_master.sv
// Single-command APB3 master for the GWCT debug path with
// alignment rejection and a watchdog on stalled slaves.
module gwct_apb_master
    import gwct_apb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES   = 1024,
    parameter int ADDR_ALIGN_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic        cmd_write,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [31:0] cmd_rdata,
    output logic        cmd_error,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    apb_state_e  state_q;
    apb_state_e  state_d;
    logic        psel_d;
    logic        penable_d;
    logic        ready_d;
    logic        misaligned;
    logic        expired;
    logic        wd_clr;
    logic        wd_en;
    logic [31:0] rdata_q;
    logic        err_q;

    assign misaligned = is_misaligned(cmd_addr, ADDR_ALIGN_CHECK);

    gwct_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expired(expired)
    );

    // Bus strobes are flopped from the next state so they leave clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= APB_IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            state_q   <= state_d;
            psel      <= psel_d;
            penable   <= penable_d;
            cmd_ready <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            APB_IDLE: begin
                if (cmd_valid) begin
                    state_d = misaligned ? APB_RESP : APB_SETUP;
                end
            end
            APB_SETUP:  state_d = APB_ACCESS;
            APB_ACCESS: begin
                if (pready || expired) begin
                    state_d = APB_RESP;
                end
            end
            APB_RESP:   state_d = APB_IDLE;
            default:    state_d = APB_IDLE;
        endcase
    end

    always_comb begin
        psel_d    = (state_d == APB_SETUP) || (state_d == APB_ACCESS);
        penable_d = (state_d == APB_ACCESS);
        ready_d   = (state_d == APB_RESP);
        wd_clr    = (state_q == APB_SETUP);
        wd_en     = (state_q == APB_ACCESS) && !pready;
    end

    // Result registers only change on a completion, so they hold between.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paddr   <= '0;
            pwdata  <= '0;
            pwrite  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == APB_IDLE && cmd_valid) begin
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
                pwrite <= cmd_write;
                if (misaligned) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end
            end
            if (state_q == APB_ACCESS) begin
                if (pready) begin
                    err_q   <= pslverr;
                    rdata_q <= (pwrite || pslverr) ? 32'h0 : prdata;
                end else if (expired) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end
            end
        end
    end

    assign cmd_rdata = rdata_q;
    assign cmd_error = err_q;

endmodule

// File: tb/tb_gwct_apb_master.sv
// Directed bench for gwct_apb_master: vector table plus reset
// abort and ignored-command sequences.
module tb_gwct_apb_master;

    localparam int TO = 8;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cmd_write;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_rdata;
    logic        cmd_error;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    always #5 clk = ~clk;

    gwct_apb_master #(
        .TIMEOUT_CYCLES  (TO),
        .ADDR_ALIGN_CHECK(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_write(cmd_write),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_rdata(cmd_rdata),
        .cmd_error(cmd_error),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        int          waits;
        logic [31:0] prd;
        logic        serr;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_acc;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] prev_rd = '0;
    logic        prev_err = 1'b0;
    vec_t        vecs[9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input bit poke);
        int cyc = 0;
        int acc = 0;
        int nsel = 0;
        bit done = 0;
        @(negedge clk);
        chk("ready_one_cycle", 32'(cmd_ready), 32'd0);
        chk("rdata_held", cmd_rdata, prev_rd);
        chk("error_held", 32'(cmd_error), 32'(prev_err));
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_write = v.wr;
        cmd_valid = 1'b1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            cmd_valid = 1'b0;
            pready    = 1'b0;
            pslverr   = 1'b0;
            prdata    = 32'h0BAD_0BAD;
            if (psel) begin
                nsel++;
                chk("paddr_stable", paddr, v.addr);
                chk("pwdata_stable", pwdata, v.wdata);
                chk("pwrite_stable", 32'(pwrite), 32'(v.wr));
            end
            if (psel && !penable && poke) begin
                cmd_valid = 1'b1;
                cmd_addr  = 32'h0000_0080;
                cmd_wdata = 32'h5555_AAAA;
                cmd_write = ~v.wr;
            end
            if (psel && penable) begin
                acc++;
                if (acc == v.waits + 1) begin
                    pready  = 1'b1;
                    prdata  = v.prd;
                    pslverr = v.serr;
                end
            end
            if (cmd_ready) begin
                done = 1;
                chk("latency", 32'(cyc), 32'(v.exp_lat));
                chk("cmd_rdata", cmd_rdata, v.exp_rd);
                chk("cmd_error", 32'(cmd_error), 32'(v.exp_err));
                chk("access_cycles", 32'(acc), 32'(v.exp_acc));
                chk("psel_cycles", 32'(nsel),
                    32'(v.exp_acc == 0 ? 0 : v.exp_acc + 1));
                chk("psel_in_resp", 32'(psel), 32'd0);
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL no_completion: got no cmd_ready expected one");
        end
        pready    = 1'b0;
        cmd_valid = 1'b0;
        prev_rd   = v.exp_rd;
        prev_err  = v.exp_err;
    endtask

    initial begin
        //          addr          wdata         wr waits prdata        serr exp_rd        err lat acc
        vecs[0] = '{32'h0000_0010, 32'h0,        0, 0,     32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 3,  1};
        vecs[1] = '{32'h0000_0004, 32'h1234_5678, 1, 3,     32'hAAAA_5555, 0, 32'h0,         0, 6,  4};
        vecs[2] = '{32'h0000_0008, 32'h0,        0, 0,     32'hFFFF_FFFF, 1, 32'h0,         1, 3,  1};
        vecs[3] = '{32'h0000_000C, 32'h0,        0, NEVER, 32'h1111_1111, 0, 32'h0,         1, 10, TO};
        vecs[4] = '{32'h0000_0020, 32'h0,        0, 1,     32'hCAFE_F00D, 0, 32'hCAFE_F00D, 0, 4,  2};
        vecs[5] = '{32'h0000_0003, 32'h0,        0, 0,     32'h0,         0, 32'h0,         1, 1,  0};
        vecs[6] = '{32'h0000_0006, 32'h7777_7777, 1, 0,     32'h0,         0, 32'h0,         1, 1,  0};
        vecs[7] = '{32'h0000_0100, 32'h0BEE_F00D, 1, 2,     32'h0,         1, 32'h0,         1, 5,  3};
        vecs[8] = '{32'h0000_0200, 32'h0,        0, TO-1,  32'h0123_4567, 0, 32'h0123_4567, 0, 10, TO};

        rst       = 1'b1;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_write = 1'b0;
        cmd_valid = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_cmd_rdata", cmd_rdata, 32'd0);
        chk("rst_cmd_error", 32'(cmd_error), 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run(vecs[i], 1'b0);
        end

        // Abort a stalled read with reset during ACCESS.
        @(negedge clk);
        cmd_addr  = 32'h0000_0050;
        cmd_write = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_access", 32'(penable), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_psel", 32'(psel), 32'd0);
        chk("abort_penable", 32'(penable), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_ready", 32'(cmd_ready), 32'd0);
        end
        rst      = 1'b0;
        prev_rd  = '0;
        prev_err = 1'b0;

        run('{32'h0000_0040, 32'h0, 0, 0, 32'h600D_D00D, 0,
              32'h600D_D00D, 0, 3, 1}, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ignored_cmd_no_psel", 32'(psel), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
